// File: rtl/mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-W mod n, one bit of a per cycle.
// Optional MONT_MUL_ERR_EN adds an err output that fast-fails requests with an even modulus.
module mont_mul #(
  parameter int W  = 2048,
  parameter int CW = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
`ifdef MONT_MUL_ERR_EN
  ,
  output logic         err
`endif
);

  typedef enum logic [1:0] {IDLE, LOOP, CORR, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q, b_q, n_q;
  logic [W+1:0]  s_q;
  logic [CW-1:0] i_q;
  logic [W+1:0]  t_add, t_red;
  logic [W-1:0]  s_sub;

  // a_q is shifted right each iteration, so a_q[0] is the current multiplier bit.
  always_comb begin
    t_add = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    t_red = t_add[0] ? t_add + {2'b00, n_q} : t_add;
    s_sub = s_q[W-1:0] - n_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      s_q    <= '0;
      i_q    <= '0;
`ifdef MONT_MUL_ERR_EN
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef MONT_MUL_ERR_EN
            if (n[0] == 1'b0 || n == '0) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else
`endif
            begin
              a_q   <= a;
              b_q   <= b;
              n_q   <= n;
              s_q   <= '0;
              i_q   <= '0;
              busy  <= 1'b1;
              state <= LOOP;
`ifdef MONT_MUL_ERR_EN
              err   <= 1'b0;
`endif
            end
          end
        end
        LOOP: begin
          s_q <= t_red >> 1;
          a_q <= a_q >> 1;
          i_q <= i_q + 1'b1;
          if (i_q == CW'(W - 1)) state <= CORR;
        end
        CORR: begin
          // S < 2N here, so a single conditional subtract fully reduces it.
          result <= (s_q >= {2'b00, n_q}) ? s_sub : s_q[W-1:0];
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul.sv
// Scoreboard bench for mont_mul at W=8: expected results come from a brute-force a*b*R^-1 mod n search.
module tb_mont_mul;
  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0, n = 8'd13;
  logic         busy, done;
  logic [W-1:0] result;
`ifdef MONT_MUL_ERR_EN
  logic         err;
`endif

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ecnt  = 0;

  mont_mul #(.W(W), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef MONT_MUL_ERR_EN
    ,
    .err    (err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Unique x in [0,n) with x*R == a*b (mod n), valid for odd n.
  function automatic logic [W-1:0] model(input int av, input int bv, input int nv);
    for (int x = 0; x < nv; x++)
      if (((x << W) % nv) == ((av * bv) % nv)) return W'(x);
    return '0;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) chk("spurious_done", done, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", ecnt, e.cyc);
`ifdef MONT_MUL_ERR_EN
        chk("err", err, e.err);
`endif
      end
    end
  end

  task automatic issue(input int av, input int bv, input int nv);
    exp_t e;
    @(posedge clk); #1;
    a = W'(av); b = W'(bv); n = W'(nv); start = 1'b1;
    e.res = model(av, bv, nv);
    e.cyc = ecnt + W + 2;
    e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); n = W'($urandom);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    exp_t e;
    int   c, nv;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    @(negedge clk) rst = 1'b0;

    // Basic op plus busy profile over cycles 1..W+2.
    issue(5, 7, 13);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      chk("busy_profile", busy, (k <= W + 1) ? 1 : 0);
    end
    drain(30);

    issue(9, 9, 13); drain(30);
    issue(1, 1, 13); drain(30);

    // start held high across two ops: back-to-back at W+3 spacing.
    @(posedge clk); #1;
    a = 8'd0; b = 8'd12; n = 8'd13; start = 1'b1;
    c = ecnt;
    e.res = model(0, 12, 13); e.cyc = c + W + 2;     e.err = 1'b0; sb.push_back(e);
    e.res = model(12, 12, 13); e.cyc = c + 2 * W + 5; e.err = 1'b0; sb.push_back(e);
    @(posedge clk); #1;
    a = 8'd12; b = 8'd12;
    repeat (12) @(posedge clk);
    #1 start = 1'b0;
    drain(40);

    // start pulsed during LOOP must be ignored.
    issue(5, 7, 13);
    repeat (3) @(posedge clk);
    #1 a = 8'd3; b = 8'd4; n = 8'd13; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain(30);
    repeat (15) @(posedge clk);

    // Async reset mid-operation: abort, no done, then a clean restart.
    issue(5, 7, 13);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    issue(12, 12, 13); drain(30);

    for (int k = 0; k < 6; k++) begin
      nv = $urandom_range(3, 255) | 1;
      issue($urandom_range(0, nv - 1), $urandom_range(0, nv - 1), nv);
      drain(30);
    end

`ifdef MONT_MUL_ERR_EN
    issue(1, 1, 13); drain(30);
    @(posedge clk); #1;
    a = 8'd5; b = 8'd7; n = 8'd12; start = 1'b1;
    e.res = model(1, 1, 13); e.cyc = ecnt + 1; e.err = 1'b1; sb.push_back(e);
    @(posedge clk); #1 start = 1'b0;
    drain(10);
    issue(5, 7, 13); drain(30);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mont_mul.md
Name: mont_mul

Overview:
- Radix-2, bit-serial Montgomery multiplier; sits directly downstream of the Montgomery-domain conversion stage in the RSA datapath.
- Consumes operands already converted to Montgomery form (x·R mod n).
- Produces result = a·b·R⁻¹ mod n, with R = 2^W.
- Chained by the modular-exponentiation controller for square/multiply steps; one operation in flight at a time.

Parameters:
- W, 2048, operand/modulus width in bits; also the loop iteration count (R = 2^W).
- CW, 12, iteration counter width; must satisfy 2^CW > W.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  W  multiplicand, Montgomery form, must be < n.
- b  input  W  multiplier, Montgomery form, must be < n.
- n  input  W  modulus, must be odd.
- busy  output  1  high from the cycle after start is accepted through the CORR state.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  W  a·b·R⁻¹ mod n; held until the next accepted start.

Behaviour:
- Reset values: reset (rst, asynchronous, active-high; clock clk) forces:
  - state = IDLE, busy = 0, done = 0, result = 0;
  - internal S = 0, counter = 0.
- Reset mid-operation: aborts the operation immediately; no done pulse is produced.
- Internal registers:
  - A, B, N operand copies, W bits each, latched at start;
  - accumulator S, W+2 bits (no overflow, since S < 2n throughout);
  - counter i, CW bits.
- IDLE:
  - start = 1 → latch a, b, n; S ← 0; i ← 0; go to LOOP.
  - Inputs are not used after the latch cycle and may change freely.
- LOOP, one iteration per cycle:
  - T = S + (A[i] ? B : 0);
  - if T[0] = 1, T = T + N;
  - S ← T >> 1; i ← i + 1.
  - After the iteration with i = W−1, go to CORR.
- CORR: result ← (S ≥ N) ? S − N : S (truncated to W bits); go to DONE.
- DONE: done = 1 for exactly this cycle; go to IDLE.
- start handling:
  - Ignored in LOOP, CORR and DONE; no queuing.
  - start held high continuously → a new operation is accepted in the first IDLE cycle after DONE.
- Latency: start sampled at edge k → done high during cycle k+W+2. Throughput: one operation per W+3 cycles.
- Boundary conditions:
  - a = 0 or b = 0 → result 0.
  - a = b = R mod n → result = R mod n (Montgomery identity).
- Precondition violations (n even, a ≥ n or b ≥ n): result is unspecified, but timing and the done pulse are unchanged.

Optional Feature:
- Macro: MONT_MUL_ERR_EN.
- Defined:
  - Adds output port err, 1 bit, reset 0.
  - In IDLE with start = 1 and (n[0] = 0 or n = 0): no latch, no LOOP; next cycle is DONE with done = 1 and err = 1; result unchanged.
  - Normal operations drive err = 0 on their done pulse.
  - err is valid only while done = 1 and is held until the next accepted start.
- Undefined: no err port; the module runs the normal LOOP/CORR/DONE sequence regardless of n.

Test Plan:
- W=8, n=13, a=5, b=7, one start pulse → busy for cycles 1..9, done in cycle 10 (start sampled at edge 0), result = 1.
- W=8, n=13, a=b=9 (R mod 13) → result = 9; then a=1, b=1 → result = 3 (R⁻¹ mod 13).
- W=8, n=13:
  - a=0, b=12 → result = 0;
  - a=12, b=12 → result = 3;
  - start held high across both ops → second done exactly W+3 = 11 cycles after the first.
- Assert rst at cycle 5 of a W=8 operation → busy = 0, result = 0, no done pulse; fresh start afterwards completes normally with the correct value.
- Pulse start during LOOP with different a/b → ignored; the original operation's result is unchanged and only one done pulse occurs.
- With MONT_MUL_ERR_EN, n=12, start → done and err high in the cycle after start, result unchanged; then n=13, a=5, b=7 → err = 0, result = 1.
